bicubic_win_ctrl: RTL

- Fetch sequencer for the bicubic resize datapath.
- Walks the source image in raster order and issues reads to the synchronous source-image memory (1-cycle read latency).
- Presents each returned pixel once to the pixel/line delay chains (shift_en/shift_din), and flags when a full 4x4 neighbourhood window is available.
- Downstream backpressure (win_ready) throttles the whole chain through a 1-entry skid register, so no pixel is lost or duplicated.

---
 rtl/bicubic_win_ctrl_if.sv | 30 +++
 rtl/bicubic_win_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/bicubic_win_ctrl_if.sv
// Handshake/bus bundle between the bicubic fetch sequencer, source memory and delay chains.
interface bicubic_win_ctrl_if #(
    parameter int BIT = 8,
    parameter int AW  = 8,
    parameter int XW  = 4,
    parameter int YW  = 4
);
    logic           start;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [BIT-1:0] rd_data;
    logic           win_ready;
    logic           shift_en;
    logic [BIT-1:0] shift_din;
    logic           win_valid;
    logic [XW-1:0]  win_x;
    logic [YW-1:0]  win_y;

    modport master (
        input  start, rd_data, win_ready,
        output busy, done, rd_en, rd_addr, shift_en, shift_din, win_valid, win_x, win_y
    );

    modport slave (
        output start, rd_data, win_ready,
        input  busy, done, rd_en, rd_addr, shift_en, shift_din, win_valid, win_x, win_y
    );
endinterface

// File: rtl/bicubic_win_ctrl.sv
// Raster fetch sequencer: one read in flight, 1-entry skid under backpressure,
// presents each pixel once to the delay chains and flags complete 4x4 windows.
module bicubic_win_ctrl #(
    parameter int BIT   = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int AW    = 8,
    parameter int XW    = 4,
    parameter int YW    = 4
) (
    input logic               CLK,
    input logic               RST,
    bicubic_win_ctrl_if.master bus
);
    localparam int N = IMG_W * IMG_H;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

    state_t         state, state_nx;
    logic [AW-1:0]  fcnt;
    logic           rd_pend;
    logic           skid_full;
    logic [BIT-1:0] skid;
    logic [XW-1:0]  px;
    logic [YW-1:0]  py;
    logic           rd_en, shift_en, last_addr, last_pix;

    always_comb begin
        rd_en     = (state == FETCH) && bus.win_ready;
        // A pending return and a full skid are mutually exclusive, so at most one source.
        shift_en  = bus.win_ready && (rd_pend || skid_full);
        last_addr = (fcnt == AW'(N - 1));
        last_pix  = (px == XW'(IMG_W - 1)) && (py == YW'(IMG_H - 1));
        state_nx  = state;
        case (state)
            IDLE:    if (bus.start) state_nx = FETCH;
            FETCH:   if (rd_en && last_addr) state_nx = WAIT;
            WAIT:    if (shift_en && last_pix) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            fcnt      <= '0;
            rd_pend   <= 1'b0;
            skid_full <= 1'b0;
            skid      <= '0;
            px        <= '0;
            py        <= '0;
        end else begin
            state   <= state_nx;
            rd_pend <= rd_en;
            if (state == IDLE && bus.start) begin
                fcnt <= '0;
                px   <= '0;
                py   <= '0;
            end else begin
                if (rd_en) fcnt <= fcnt + 1'b1;
                if (shift_en) begin
                    if (px == XW'(IMG_W - 1)) begin
                        px <= '0;
                        py <= py + 1'b1;
                    end else begin
                        px <= px + 1'b1;
                    end
                end
            end
            // Returned data that cannot be presented is parked; it drains on the next ready.
            if (rd_pend && !bus.win_ready) begin
                skid      <= bus.rd_data;
                skid_full <= 1'b1;
            end else if (skid_full && bus.win_ready) begin
                skid_full <= 1'b0;
            end
        end
    end

    assign bus.busy      = (state == FETCH) || (state == WAIT);
    assign bus.done      = (state == DONE);
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = fcnt;
    assign bus.shift_en  = shift_en;
    assign bus.shift_din = shift_en ? (skid_full ? skid : bus.rd_data) : '0;
    assign bus.win_valid = shift_en && (px >= XW'(3)) && (py >= YW'(3));
    assign bus.win_x     = px;
    assign bus.win_y     = py;
endmodule
